// File: rtl/light_decoder.sv
// Tail-lamp pattern decoder: classifies sampled 6-bit lamp patterns into turn, brake, hazard and fault modes.
// Optional LIGHT_DEC_ERRCNT_EN enables the saturating err_cnt counter; otherwise err_cnt is tied to zero.
module light_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       lights,
    input  logic             sample_en,
    output logic [2:0]       mode,
    output logic             brake_on,
    output logic [CNT_W-1:0] sweep_cnt,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_BRAKE  = 3'd3,
        ST_HAZARD = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P3 = 2'd3;

    // Phase lookup returns {valid, phase}; the left half fills from bit 0, the right from bit 2.
    function automatic logic [2:0] left_phase(input logic [2:0] h);
        case (h)
            3'b000:  left_phase = 3'b100;
            3'b001:  left_phase = 3'b101;
            3'b011:  left_phase = 3'b110;
            3'b111:  left_phase = 3'b111;
            default: left_phase = 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] right_phase(input logic [2:0] h);
        case (h)
            3'b000:  right_phase = 3'b100;
            3'b100:  right_phase = 3'b101;
            3'b110:  right_phase = 3'b110;
            3'b111:  right_phase = 3'b111;
            default: right_phase = 3'b000;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [5:0]       q_q, q_d;
    logic             brake_q, brake_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;
    logic             armed_q;

    logic [2:0] lph, rph, qlph, qrph;
    logic [1:0] ql_next, qr_next;
    logic       stay_left, stay_right, sweep_wrap, eval;

    assign lph     = left_phase(lights[5:3]);
    assign rph     = right_phase(lights[2:0]);
    assign qlph    = left_phase(q_q[5:3]);
    assign qrph    = right_phase(q_q[2:0]);
    assign ql_next = qlph[1:0] + 2'd1;
    assign qr_next = qrph[1:0] + 2'd1;

    // sample_en is a single-cycle qualifier with no backpressure; the first edge after reset release is ignored.
    assign eval = sample_en && armed_q;

    assign stay_left  = (state_q == ST_LEFT) && qlph[2] && lph[2] && rph[2]
                        && (lph[1:0] == ql_next) && (lights[2:0] == q_q[2:0])
                        && ((rph[1:0] == P0) || (rph[1:0] == P3));
    assign stay_right = (state_q == ST_RIGHT) && qrph[2] && lph[2] && rph[2]
                        && (rph[1:0] == qr_next) && (lights[5:3] == q_q[5:3])
                        && ((lph[1:0] == P0) || (lph[1:0] == P3));
    assign sweep_wrap = (stay_left && (lph[1:0] == P0)) || (stay_right && (rph[1:0] == P0));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        brake_d = brake_q;
        err_d   = 1'b0;
        sweep_d = sweep_q;
        if (eval) begin
            q_d = lights;
            if (!lph[2] || !rph[2]) begin
                state_d = ST_FAULT;
            end else if (stay_left || stay_right) begin
                state_d = state_q;
                if (sweep_wrap && (sweep_q != {CNT_W{1'b1}})) begin
                    sweep_d = sweep_q + CNT_W'(1);
                end
            end else if (lights == 6'b000000) begin
                state_d = ((state_q == ST_HAZARD) && (q_q == 6'b111111)) ? ST_HAZARD : ST_IDLE;
            end else if (lights == 6'b111111) begin
                state_d = (q_q == 6'b000000) ? ST_HAZARD : ST_BRAKE;
            end else if ((lph[1:0] == P1) && ((rph[1:0] == P0) || (rph[1:0] == P3))) begin
                state_d = ST_LEFT;
            end else if ((rph[1:0] == P1) && ((lph[1:0] == P0) || (lph[1:0] == P3))) begin
                state_d = ST_RIGHT;
            end else begin
                state_d = ST_FAULT;
            end
            err_d   = (state_d == ST_FAULT);
            brake_d = ((state_d == ST_LEFT) && (rph[1:0] == P3))
                   || ((state_d == ST_RIGHT) && (lph[1:0] == P3));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= 6'b000000;
            brake_q <= 1'b0;
            err_q   <= 1'b0;
            sweep_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            brake_q <= brake_d;
            err_q   <= err_d;
            sweep_q <= sweep_d;
            armed_q <= 1'b1;
        end
    end

    assign mode      = state_q;
    assign brake_on  = brake_q;
    assign sweep_cnt = sweep_q;
    assign err_pulse = err_q;

`ifdef LIGHT_DEC_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_light_decoder.sv
// Scoreboard bench for light_decoder: expected {mode, brake_on, sweep_cnt, err_pulse} words are queued per sample.
// Honors LIGHT_DEC_ERRCNT_EN when computing expected err_cnt.
module tb_light_decoder;
  localparam int CNT_W = 8;
  localparam int EW = 3 + 1 + CNT_W + 1;
`ifdef LIGHT_DEC_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       lights = 6'b0;
  logic             sample_en = 1'b0;
  logic [2:0]       mode;
  logic             brake_on;
  logic [CNT_W-1:0] sweep_cnt;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;

  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  light_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .lights(lights), .sample_en(sample_en),
    .mode(mode), .brake_on(brake_on), .sweep_cnt(sweep_cnt),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [2:0] m, input logic b,
                                       input logic [CNT_W-1:0] s, input logic e);
    mk = {m, b, s, e};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_en = 1'b0;
    lights = 6'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // driver: one qualified sample, expected result queued alongside it
  task automatic drive_sample(input logic [5:0] p, input logic [EW-1:0] e);
    @(negedge clk);
    lights = p;
    sample_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] obs;
    @(negedge clk);
    reset = 1'b1;
    #2;
    obs = {mode, brake_on, sweep_cnt, err_pulse};
    vectors++;
    if (obs !== '0 || err_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%h err_cnt=%0d exp=0 err_cnt=0", obs, err_cnt);
    end
    // sample_en on the releasing edge must be ignored
    lights = 6'b001000;
    sample_en = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    #1;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    obs = {mode, brake_on, sweep_cnt, err_pulse};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_release_ignore got=%h exp=0", obs);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_table(input string name, input int n,
                           input logic [5:0] pats [8], input logic [EW-1:0] exps [8]);
    logic [EW-1:0] obs, e;
    for (int i = 0; i < n; i++) begin
      drive_sample(pats[i], exps[i]);
      e = exp_q.pop_front();
      obs = {mode, brake_on, sweep_cnt, err_pulse};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL %s[%0d] got=%h exp=%h", name, i, obs, e);
      end
    end
  endtask

  task automatic test_left_sweep();
    logic [5:0] pats [8];
    logic [EW-1:0] exps [8];
    do_reset();
    pats = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000, 6'b0, 6'b0, 6'b0};
    exps = '{mk(1,0,0,0), mk(1,0,0,0), mk(1,0,0,0), mk(1,0,1,0), mk(1,0,1,0), '0, '0, '0};
    run_table("left_sweep", 5, pats, exps);
  endtask

  task automatic test_right_brake();
    logic [5:0] pats [8];
    logic [EW-1:0] exps [8];
    do_reset();
    pats = '{6'b111100, 6'b111110, 6'b111111, 6'b111000, 6'b0, 6'b0, 6'b0, 6'b0};
    exps = '{mk(2,1,0,0), mk(2,1,0,0), mk(2,1,0,0), mk(2,1,1,0), '0, '0, '0, '0};
    run_table("right_brake", 4, pats, exps);
    do_reset();
    pats = '{6'b001111, 6'b011111, 6'b111111, 6'b000111, 6'b0, 6'b0, 6'b0, 6'b0};
    exps = '{mk(1,1,0,0), mk(1,1,0,0), mk(1,1,0,0), mk(1,1,1,0), '0, '0, '0, '0};
    run_table("left_brake", 4, pats, exps);
  endtask

  task automatic test_hazard();
    logic [5:0] pats [8];
    logic [EW-1:0] exps [8];
    do_reset();
    pats = '{6'b000000, 6'b111111, 6'b000000, 6'b111111, 6'b111111, 6'b000000, 6'b0, 6'b0};
    exps = '{mk(0,0,0,0), mk(4,0,0,0), mk(4,0,0,0), mk(4,0,0,0), mk(3,0,0,0), mk(0,0,0,0), '0, '0};
    run_table("hazard_brake", 6, pats, exps);
  endtask

  task automatic test_fault();
    logic [5:0] pats [9];
    logic [EW-1:0] exps [9];
    logic [EW-1:0] obs, e;
    int n_err = 0;
    do_reset();
    pats = '{6'b010000, 6'b010000, 6'b000100, 6'b011000, 6'b001000,
             6'b111000, 6'b001000, 6'b011111, 6'b001100};
    exps = '{mk(7,0,0,1), mk(7,0,0,1), mk(2,0,0,0), mk(7,0,0,1), mk(1,0,0,0),
             mk(7,0,0,1), mk(1,0,0,0), mk(7,0,0,1), mk(7,0,0,1)};
    for (int i = 0; i < 9; i++) begin
      drive_sample(pats[i], exps[i]);
      e = exp_q.pop_front();
      if (e[0]) n_err++;
      obs = {mode, brake_on, sweep_cnt, err_pulse};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL fault[%0d] got=%h exp=%h", i, obs, e);
      end
      vectors++;
      if (err_cnt !== (ERRCNT_ON ? CNT_W'(n_err) : '0)) begin
        miscompares++;
        $display("FAIL err_cnt[%0d] got=%0d exp=%0d", i, err_cnt, ERRCNT_ON ? n_err : 0);
      end
      // pulse must drop on the following unqualified cycle
      @(posedge clk);
      #1;
      vectors++;
      if (err_pulse !== 1'b0 || mode !== e[EW-1 -: 3]) begin
        miscompares++;
        $display("FAIL err_pulse_width[%0d] got pulse=%0b mode=%0d exp pulse=0 mode=%0d",
                 i, err_pulse, mode, e[EW-1 -: 3]);
      end
    end
  endtask

  task automatic test_saturation_gating();
    logic [5:0] loop_pats [4];
    logic [EW-1:0] obs, e, last;
    int sweeps = 0;
    int gap;
    do_reset();
    loop_pats = '{6'b011000, 6'b111000, 6'b000000, 6'b001000};
    drive_sample(6'b001000, mk(1,0,0,0));
    last = exp_q.pop_front();
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        if (j == 2) sweeps++;
        drive_sample(loop_pats[j], mk(1, 0, CNT_W'((sweeps > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : sweeps), 0));
        e = exp_q.pop_front();
        obs = {mode, brake_on, sweep_cnt, err_pulse};
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL saturation[%0d.%0d] got=%h exp=%h", k, j, obs, e);
        end
        last = e;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          lights = 6'($urandom_range(0, 63));
          @(posedge clk);
          #1;
          obs = {mode, brake_on, sweep_cnt, err_pulse};
          vectors++;
          if (obs !== last) begin
            miscompares++;
            $display("FAIL gating[%0d.%0d] got=%h exp=%h", k, j, obs, last);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] pats [8];
    logic [EW-1:0] exps [8];
    logic [EW-1:0] obs, e;
    do_reset();
    pats = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000, 6'b011000, 6'b0, 6'b0};
    exps = '{mk(1,0,0,0), mk(1,0,0,0), mk(1,0,0,0), mk(1,0,1,0), mk(1,0,1,0), mk(1,0,1,0), '0, '0};
    run_table("pre_reset_sweep", 6, pats, exps);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    obs = {mode, brake_on, sweep_cnt, err_pulse};
    vectors++;
    if (obs !== '0 || err_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset got=%h err_cnt=%0d exp=0 err_cnt=0", obs, err_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_sample(6'b111000, mk(7,0,0,1));
    e = exp_q.pop_front();
    obs = {mode, brake_on, sweep_cnt, err_pulse};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL post_reset_fault got=%h exp=%h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_left_sweep();
    test_right_brake();
    test_hazard();
    test_fault();
    test_saturation_gating();
    test_async_reset();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_decoder.md
LIGHT_DECODER -- requirements
Module: light_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of sweep_cnt and err_cnt.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port lights  input  6  observed tail-lamp pattern; [5:3] left half, [2:0] right half.
REQ-005 SHALL have port sample_en  input  1  one-cycle qualifier; lights evaluated only when high.
REQ-006 SHALL have port mode  output  3  decoded mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 BRAKE, 4 HAZARD, 7 FAULT.
REQ-007 SHALL have port brake_on  output  1  high while a sweep runs with the opposite half steady-on.
REQ-008 SHALL have port sweep_cnt  output  CNT_W  count of completed turn sweeps, saturating.
REQ-009 SHALL have port err_pulse  output  1  one-cycle pulse on each evaluation resolving to FAULT.
REQ-010 SHALL have port err_cnt  output  CNT_W  count of FAULT evaluations, saturating.

Function
REQ-011 SHALL classify each half into a phase: left 000=P0, 001=P1, 011=P2, 111=P3; right 000=P0, 100=P1, 110=P2, 111=P3; any other code is invalid.
REQ-012 SHALL hold q, the last sampled pattern, updated on every sample_en, reset 000000.
REQ-013 SHALL, on sample_en with current pattern p, select the next state using the first matching rule of REQ-014..REQ-019; all outputs register one cycle after sample_en.
REQ-014 Rule 1: SHALL go to FAULT if either half of p is invalid.
REQ-015 Rule 2: SHALL, in LEFT or RIGHT, stay if the active half advances exactly one phase (P0->P1->P2->P3->P0) and the inactive half equals its q value and is P0 or P3.
REQ-016 Rule 3: SHALL, for p=000000, go to HAZARD if state is HAZARD and q=111111; otherwise go to IDLE.
REQ-017 Rule 4: SHALL, for p=111111, go to HAZARD if q=000000; otherwise go to BRAKE.
REQ-018 Rule 5: SHALL go to LEFT if left half is P1 and right half is P0 or P3, or to RIGHT if right half is P1 and left half is P0 or P3.
REQ-019 Rule 6: SHALL go to FAULT otherwise.
REQ-020 SHALL increment sweep_cnt when Rule 2 applies with the active half moving P3->P0, holding at all-ones.
REQ-021 SHALL drive brake_on high only in LEFT/RIGHT with inactive half at P3; low in all other states.
REQ-022 SHALL pulse err_pulse for exactly one cycle per FAULT evaluation, including repeated FAULT evaluations.
REQ-023 SHALL leave FAULT only through Rules 2..5; no timeout.
REQ-024 SHALL hold state, q, and counters and drive err_pulse low while sample_en is low.

Reset
REQ-025 SHALL, on reset high, asynchronously set mode=0 (IDLE), q=000000, brake_on=0, sweep_cnt=0, err_pulse=0, err_cnt=0.
REQ-026 SHALL, on reset asserted mid-sweep, discard the sweep without incrementing sweep_cnt.
REQ-027 SHALL ignore a sample_en coincident with the clock edge on which reset deasserts.

Configuration
REQ-028 SHALL include err_cnt counting logic only when macro LIGHT_DEC_ERRCNT_EN is defined; err_cnt increments, saturating, on every err_pulse.
REQ-029 SHALL, without LIGHT_DEC_ERRCNT_EN, keep the err_cnt port and tie it to 0; err_pulse behaviour is unchanged.

Verification
REQ-030 Left sweep: sample 001000, 011000, 111000, 000000, 001000 -> mode=1 throughout, brake_on=0, sweep_cnt=1.
REQ-031 Right sweep with brake: sample 111100, 111110, 111111, 111000 -> mode=2, brake_on=1, sweep_cnt=1.
REQ-032 Hazard then brake: 000000, 111111, 000000, 111111, 111111 -> mode 0,4,4,4,3.
REQ-033 Fault and recovery: sample 010000 -> mode=7, err_pulse one cycle, err_cnt=1 (macro on) / 0 (macro off); then 000100 -> mode=2.
REQ-034 Saturation and gating: force 2^CNT_W+3 left sweeps with sample_en gaps -> sweep_cnt=all-ones; no state change on cycles without sample_en.
REQ-035 Async reset mid-sweep at 011000 -> all outputs zero immediately, before the next clk edge; then 111000 -> mode=7.
